// File: rtl/float_accum_pkg.sv
// Shared types and constants for float accumulator controllers.
// ACCUM_LATENCY is both the drain length and the result token delay-line depth.
package float_accum_pkg;

    localparam int ACCUM_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/float_accum_group_tracker.sv
// Prologue/stride counters that spot the last sample of each complete group and
// delay a token by the accumulator latency so it lines up with the group sum on out0.
module float_accum_group_tracker
    import float_accum_pkg::*;
#(
    parameter int STRIDE_W = 16,
    parameter int DELAY_W  = 7,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sample_en,
    input  logic                flush,
    input  logic [STRIDE_W-1:0] cfg_stride_minus_one,
    input  logic [DELAY_W-1:0]  cfg_delay,
    input  logic [LEN_W-1:0]    samples_left,
    output logic                result_valid,
    output logic                result_last
);

    localparam int CMP_W = (LEN_W > STRIDE_W) ? LEN_W : STRIDE_W;

    logic [DELAY_W-1:0]       pro_cnt_q, pro_cnt_d;
    logic [STRIDE_W-1:0]      str_cnt_q, str_cnt_d;
    logic [ACCUM_LATENCY-1:0] vld_q, vld_d;
    logic [ACCUM_LATENCY-1:0] last_q, last_d;
    logic                     token_valid;
    logic                     token_last;
    logic [CMP_W-1:0]         left_ext;
    logic [CMP_W-1:0]         stride_ext;

    assign left_ext   = CMP_W'(samples_left);
    assign stride_ext = CMP_W'(cfg_stride_minus_one);

    always_comb begin
        pro_cnt_d   = pro_cnt_q;
        str_cnt_d   = str_cnt_q;
        token_valid = 1'b0;
        token_last  = 1'b0;
        if (start) begin
            pro_cnt_d = cfg_delay;
            str_cnt_d = cfg_stride_minus_one;
        end else if (sample_en) begin
            if (pro_cnt_q != '0) begin
                pro_cnt_d = pro_cnt_q - 1'b1;
            end else if (str_cnt_q == '0) begin
                token_valid = 1'b1;
                // Final complete group: fewer than S samples remain after this one.
                token_last  = (left_ext <= stride_ext);
                str_cnt_d   = cfg_stride_minus_one;
            end else begin
                str_cnt_d = str_cnt_q - 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ACCUM_LATENCY; gi++) begin : g_delay
            if (gi == 0) begin : g_head
                assign vld_d[gi]  = flush ? 1'b0 : token_valid;
                assign last_d[gi] = flush ? 1'b0 : token_last;
            end else begin : g_tail
                assign vld_d[gi]  = flush ? 1'b0 : vld_q[gi-1];
                assign last_d[gi] = flush ? 1'b0 : last_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pro_cnt_q <= '0;
            str_cnt_q <= '0;
            vld_q     <= '0;
            last_q    <= '0;
        end else begin
            pro_cnt_q <= pro_cnt_d;
            str_cnt_q <= str_cnt_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    assign result_valid = vld_q[ACCUM_LATENCY-1];
    assign result_last  = vld_q[ACCUM_LATENCY-1] & last_q[ACCUM_LATENCY-1];

endmodule

// File: rtl/float_accum_seq.sv
// Job sequencer for one float accumulator: takes a descriptor, drives run/running,
// streams N samples without stalling, drains the pipeline and reports group sums.
module float_accum_seq
    import float_accum_pkg::*;
#(
    parameter int STRIDE_W = 16,
    parameter int DELAY_W  = 7,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [STRIDE_W-1:0] cfg_stride_minus_one,
    input  logic [DELAY_W-1:0]  cfg_delay,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                accum_run,
    output logic                accum_running,
    output logic [STRIDE_W-1:0] accum_stride_minus_one,
    output logic [DELAY_W-1:0]  accum_delay0,
    output logic                result_valid,
    output logic                result_last,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic                underrun_q, underrun_d;
    logic                abort_take;

    assign abort_take = abort && (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        stride_d   = stride_q;
        delay_d    = delay_q;
        underrun_d = underrun_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    len_d      = cfg_len;
                    stride_d   = cfg_stride_minus_one;
                    delay_d    = cfg_delay;
                    underrun_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (len_q == '0) begin
                    cnt_d   = LEN_W'(ACCUM_LATENCY - 1);
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d   = len_q - 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // No stall: the accumulator's delay counter keeps running regardless.
                if (!in_valid) underrun_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = LEN_W'(ACCUM_LATENCY - 1);
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_take) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            stride_q   <= '0;
            delay_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            stride_q   <= stride_d;
            delay_q    <= delay_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        cfg_ready     = 1'b0;
        in_ready      = 1'b0;
        accum_run     = 1'b0;
        accum_running = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_IDLE: cfg_ready = 1'b1;
            ST_RUN: begin
                accum_run     = 1'b1;
                accum_running = 1'b1;
                busy          = 1'b1;
            end
            ST_STREAM: begin
                accum_running = 1'b1;
                in_ready      = 1'b1;
                busy          = 1'b1;
            end
            ST_DRAIN: begin
                accum_running = 1'b1;
                busy          = 1'b1;
                done          = (cnt_q == '0) && !abort;
            end
            default: cfg_ready = 1'b0;
        endcase
    end

    assign accum_stride_minus_one = stride_q;
    assign accum_delay0           = delay_q;
    assign underrun               = underrun_q;

    float_accum_group_tracker #(
        .STRIDE_W (STRIDE_W),
        .DELAY_W  (DELAY_W),
        .LEN_W    (LEN_W)
    ) u_tracker (
        .clk                  (clk),
        .rst                  (rst),
        .start                (state_q == ST_RUN),
        .sample_en            (state_q == ST_STREAM),
        .flush                (abort_take),
        .cfg_stride_minus_one (stride_q),
        .cfg_delay            (delay_q),
        .samples_left         (cnt_q),
        .result_valid         (result_valid),
        .result_last          (result_last)
    );

endmodule

// File: tb/tb_float_accum_seq.sv
// Directed bench for float_accum_seq: per-cycle checks of handshake, stream gating,
// result strobes, done, underrun, abort and asynchronous reset.
module tb_float_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_len;
    logic [15:0] cfg_stride_minus_one;
    logic [6:0]  cfg_delay;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic        accum_run;
    logic        accum_running;
    logic [15:0] accum_stride_minus_one;
    logic [6:0]  accum_delay0;
    logic        result_valid;
    logic        result_last;
    logic        busy;
    logic        done;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    float_accum_seq dut (
        .clk                    (clk),
        .rst                    (rst),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_len                (cfg_len),
        .cfg_stride_minus_one   (cfg_stride_minus_one),
        .cfg_delay              (cfg_delay),
        .abort                  (abort),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .accum_run              (accum_run),
        .accum_running          (accum_running),
        .accum_stride_minus_one (accum_stride_minus_one),
        .accum_delay0           (accum_delay0),
        .result_valid           (result_valid),
        .result_last            (result_last),
        .busy                   (busy),
        .done                   (done),
        .underrun               (underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one job; cycle indices k are STREAM-relative (k=0 is the first sample).
    task automatic run_job(input int len, input int s_m1, input int d,
                           input logic [31:0] mask, input int last_c, input int done_c,
                           input int gap, input int abort_c);
        int        last_k;
        logic [31:0] m;
        m      = mask;
        last_k = (abort_c >= 0) ? abort_c : done_c;
        check("idle_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        cfg_valid            = 1'b1;
        cfg_len              = 16'(len);
        cfg_stride_minus_one = 16'(s_m1);
        cfg_delay            = 7'(d);
        tick();
        cfg_valid = 1'b0;
        check("run_accum_run", {31'd0, accum_run}, 32'd1);
        check("run_running", {31'd0, accum_running}, 32'd1);
        check("run_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("run_underrun", {31'd0, underrun}, 32'd0);
        check("run_stride", {16'd0, accum_stride_minus_one}, 32'(s_m1));
        check("run_delay0", {25'd0, accum_delay0}, 32'(d));
        tick();
        for (int k = 0; k <= last_k + 1; k++) begin
            in_valid = (k != gap);
            abort    = (k == abort_c);
            #1;
            $display("cycle %0d: rv=%0b rl=%0b done=%0b busy=%0b in_ready=%0b underrun=%0b",
                     k, result_valid, result_last, done, busy, in_ready, underrun);
            check("result_valid", {31'd0, result_valid}, {31'd0, m[k]});
            check("result_last", {31'd0, result_last}, {31'd0, k == last_c});
            check("done", {31'd0, done}, {31'd0, (abort_c < 0) && (k == done_c)});
            check("busy", {31'd0, busy}, {31'd0, k <= last_k});
            check("running", {31'd0, accum_running}, {31'd0, k <= last_k});
            check("in_ready", {31'd0, in_ready}, {31'd0, (k < len) && (k <= last_k)});
            check("cfg_ready", {31'd0, cfg_ready}, {31'd0, k > last_k});
            check("accum_run", {31'd0, accum_run}, 32'd0);
            check("underrun", {31'd0, underrun}, {31'd0, (gap >= 0) && (k > gap)});
            if (k <= last_k) tick();
        end
        abort    = 1'b0;
        in_valid = 1'b1;
    endtask

    initial begin
        rst                  = 1'b1;
        cfg_valid            = 1'b0;
        cfg_len              = '0;
        cfg_stride_minus_one = '0;
        cfg_delay            = '0;
        abort                = 1'b0;
        in_valid             = 1'b1;
        tick();
        tick();
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_running", {31'd0, accum_running}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_stride", {16'd0, accum_stride_minus_one}, 32'd0);
        rst = 1'b0;
        tick();

        // abort while idle must be ignored
        abort = 1'b1;
        #1;
        check("idle_abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        abort = 1'b0;

        // N=8, S=4, D=0: results at 7 and 11 (last), done at 11
        run_job(8, 3, 0, 32'h0000_0880, 11, 11, -1, -1);
        // N=10, S=3, D=2: results at 8 and 11 (last), done at 13
        run_job(10, 2, 2, 32'h0000_0900, 11, 13, -1, -1);
        // N=3, S=4: no results, done at 6
        run_job(3, 3, 0, 32'h0000_0000, -1, 6, -1, -1);
        // N=8, S=2 with a missing sample 3: timing unchanged, underrun sticks
        run_job(8, 1, 0, 32'h0000_0AA0, 11, 11, 3, -1);
        check("underrun_sticky", {31'd0, underrun}, 32'd1);
        // next descriptor clears underrun (checked in its RUN cycle)
        run_job(8, 1, 0, 32'h0000_0AA0, 11, 11, -1, -1);
        // abort at STREAM cycle 5: result at 5 still visible, nothing after
        run_job(8, 1, 0, 32'h0000_0020, -1, -1, -1, 5);
        tick();
        check("post_abort_result_valid", {31'd0, result_valid}, 32'd0);
        // fresh job after abort
        run_job(8, 3, 0, 32'h0000_0880, 11, 11, -1, -1);

        // rst during DRAIN of an N=3 job
        cfg_valid            = 1'b1;
        cfg_len              = 16'd3;
        cfg_stride_minus_one = 16'd0;
        cfg_delay            = 7'd0;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_mid_running", {31'd0, accum_running}, 32'd0);
        check("rst_mid_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_stride", {16'd0, accum_stride_minus_one}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
